camera_code_tx: RTL and testbench

Camera-side transmitter for the scale's product-recognition link: it takes product detections from the vision front end and drives the 3-bit `camera_output` code that `CameraModule` decodes into `product_detected`. Each detection is presented as a stable code for a fixed hold time, then the line returns to "no product" for a guard gap. A small FIFO absorbs bursts of detections so none are lost while a code is on the line. It sits between the detection source and `CameraModule`, and doubles as the stimulus generator in system-level benches.

---
 rtl/camera_pkg.sv | 34 +++
 rtl/camera_code_fifo.sv | 83 ++++++++
 rtl/camera_code_tx.sv | 165 ++++++++++++++++
 tb/tb_camera_code_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
`default_nettype none
// ============================================================================
// Module      : camera_pkg
// Description : Shared definitions for the camera product-code link. These
//               are the line-code constant and type, the transmitter state
//               enum, and a helper that sizes the hold/gap down-counter.
//               CameraModule uses the same code constants.
// Revision    : 1.0 - initial release
// ============================================================================
package camera_pkg;

    // 3-bit product code on the camera line. Codes 1..7 are products.
    typedef logic [2:0] cam_code_t;

    // Line code meaning "no product present".
    localparam cam_code_t CAM_NONE = 3'd0;

    // Transmitter states. The encoding width is stated explicitly.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } cam_tx_state_t;

    // Width of a counter that must hold max(hold, gap).
    function automatic int unsigned cam_cnt_width(input int unsigned hold,
                                                  input int unsigned gap);
        int unsigned m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 1);
    endfunction

endpackage : camera_pkg
`default_nettype wire

// File: rtl/camera_code_fifo.sv
`default_nettype none
// ============================================================================
// Module      : camera_code_fifo
// Description : Synchronous FIFO for pending product codes. It is 3 bits wide
//               and DEPTH entries deep, with a registered occupancy count and
//               full/empty flags derived from that count. The head entry is
//               always visible on head_o (show-ahead).
// Ports       : clk      - clock, rising edge
//               rst_n    - asynchronous active-low reset (pointers/count)
//               push_i   - write wdata_i (ignored when full)
//               wdata_i  - code to enqueue
//               pop_i    - drop the head entry (ignored when empty)
//               head_o   - oldest entry
//               full_o   - count == DEPTH
//               empty_o  - count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module camera_code_fifo
    import camera_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [2:0] wdata_i,
    input  logic       pop_i,
    output logic [2:0] head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w + 1)'(DEPTH);

    logic [2:0]         mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_ptr_w:0]   count_q;

    logic w_push;
    logic w_pop;

    assign full_o  = (count_q == c_full_count);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt
    // the count.
    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i  && !empty_o;

    // Storage needs no reset. Stale contents are never observable because
    // the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : camera_code_fifo
`default_nettype wire

// File: rtl/camera_code_tx.sv
`default_nettype none
// ============================================================================
// Module      : camera_code_tx
// Description : Camera-side transmitter of the product-recognition line.
//               Accepted detections are queued. Each one is driven on
//               camera_output for HOLD_CYCLES cycles, followed by GAP_CYCLES
//               cycles of CAM_NONE. Code 0 detections are accepted, dropped,
//               and flagged on drop_err.
// Ports       : clk           - clock, rising edge
//               rst_n         - asynchronous active-low reset
//               det_valid     - detection offered
//               det_code      - offered product code (0 = invalid)
//               det_ready     - a detection can be accepted this cycle
//               camera_output - registered line code (0 = no product)
//               busy          - FSM not IDLE or queue non-empty (registered)
//               drop_err      - one-cycle pulse per discarded code 0
// Revision    : 1.0 - initial release
// ============================================================================
module camera_code_tx
    import camera_pkg::*;
#(
    parameter int HOLD_CYCLES = 50,
    parameter int GAP_CYCLES  = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       det_valid,
    input  logic [2:0] det_code,
    output logic       det_ready,
    output logic [2:0] camera_output,
    output logic       busy,
    output logic       drop_err
);

    localparam int unsigned c_cnt_w = cam_cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [c_cnt_w-1:0] c_hold = c_cnt_w'(HOLD_CYCLES);
    localparam logic [c_cnt_w-1:0] c_gap  = c_cnt_w'(GAP_CYCLES);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    cam_tx_state_t      state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q,   cnt_d;
    cam_code_t          out_q,   out_d;
    logic               busy_q,  busy_d;
    logic               drop_q,  drop_d;

    logic      w_full;
    logic      w_empty;
    cam_code_t w_head;
    logic      w_accept;
    logic      w_push;
    logic      w_pop;

    // Ready comes only from the registered count. A pop on the same edge
    // does not make room for a push.
    assign w_accept = det_valid && !w_full;
    assign w_push   = w_accept && (det_code != CAM_NONE);

    camera_code_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .wdata_i (det_code),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // ------------------------------------------------------------------
    // State register (including the counter and registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= CAM_NONE;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        w_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    out_d   = w_head;
                    cnt_d   = c_hold;
                    state_d = DRIVE;
                end
            end

            DRIVE: begin
                if (cnt_q <= c_one) begin
                    out_d   = CAM_NONE;
                    cnt_d   = c_gap;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            GAP: begin
                if (cnt_q <= c_one) begin
                    // Chain straight into the next code so that queued
                    // codes are separated by exactly GAP_CYCLES zeros.
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        out_d   = w_head;
                        cnt_d   = c_hold;
                        state_d = DRIVE;
                    end else begin
                        out_d   = CAM_NONE;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                out_d   = CAM_NONE;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Busy is computed one edge early so that the registered flag
        // matches "not IDLE or queue non-empty" in the same cycle. A pop
        // always moves the FSM to DRIVE, so the pre-edge empty flag plus
        // any push covers the queue side.
        busy_d = (state_d != IDLE) || w_push || !w_empty;
        drop_d = w_accept && (det_code == CAM_NONE);
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        det_ready     = !w_full;
        camera_output = out_q;
        busy          = busy_q;
        drop_err      = drop_q;
    end

endmodule : camera_code_tx
`default_nettype wire

// File: tb/tb_camera_code_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_code_tx
// Description : Self-checking bench for camera_code_tx. A schedule model
//               computes, for every accepted code, the edge at which its
//               hold window starts. Expected line code, busy, ready and
//               drop_err for any cycle follow from that schedule by plain
//               interval arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_camera_code_tx;

    localparam int H = 50;
    localparam int G = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       det_valid = 1'b0;
    logic [2:0] det_code = 3'd0;
    logic       det_ready;
    logic [2:0] camera_output;
    logic       busy;
    logic       drop_err;

    always #5 clk = ~clk;

    camera_code_tx #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .det_valid     (det_valid),
        .det_code      (det_code),
        .det_ready     (det_ready),
        .camera_output (camera_output),
        .busy          (busy),
        .drop_err      (drop_err)
    );

    // ------------------------------------------------------------------
    // Schedule model. Edge n means the n-th rising edge since start. Each
    // accepted code occupies the queue over [acc, start). It is on the line
    // over [start, start+H), and keeps the block busy until start+H+G.
    // ------------------------------------------------------------------
    typedef struct {
        int         acc;
        int         start;
        logic [2:0] code;
    } rec_t;

    rec_t recs[$];
    int   cyc        = 0;
    bit   m_acc      = 1'b0;
    int   m_acc_edge = 0;
    bit   m_drop     = 1'b0;
    int   last_start = 0;
    bit   have_last  = 1'b0;

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    function automatic int occupancy(input int n);
        int c;
        c = 0;
        foreach (recs[i]) if (recs[i].acc <= n && n < recs[i].start) c++;
        return c;
    endfunction

    function automatic logic exp_ready(input int n);
        return occupancy(n) < D;
    endfunction

    function automatic logic [2:0] exp_out(input int n);
        foreach (recs[i]) if (recs[i].start <= n && n < recs[i].start + H) return recs[i].code;
        return 3'd0;
    endfunction

    function automatic logic exp_busy(input int n);
        foreach (recs[i]) if (recs[i].acc <= n && n < recs[i].start + H + G) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int   n;
        rec_t r;
        if (!rst_n) begin
            recs.delete();
            have_last = 1'b0;
            m_acc     = 1'b0;
            m_drop    = 1'b0;
        end else begin
            n      = cyc + 1;
            m_acc  = det_valid && exp_ready(cyc);
            m_drop = m_acc && (det_code == 3'd0);
            if (m_acc) m_acc_edge = n;
            if (m_acc && det_code != 3'd0) begin
                r.acc   = n;
                r.code  = det_code;
                r.start = n + 1;
                if (have_last && (last_start + H + G) > r.start) r.start = last_start + H + G;
                recs.push_back(r);
                last_start = r.start;
                have_last  = 1'b1;
            end
            cyc = n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("camera_output", 32'(camera_output), 32'(exp_out(cyc)));
        chk("busy",          32'(busy),          32'(exp_busy(cyc)));
        chk("det_ready",     32'(det_ready),     32'(exp_ready(cyc)));
        chk("drop_err",      32'(drop_err),      32'(m_drop));
    end

    // Record the order of distinct codes that appear on the line.
    logic [2:0] seen[$];
    logic [2:0] prev_out = 3'd0;
    always @(negedge clk) begin
        if (camera_output != prev_out && camera_output != 3'd0) seen.push_back(camera_output);
        prev_out = camera_output;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send(input logic [2:0] c);
        int k;
        det_valid = 1'b1;
        det_code  = c;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_acc && k < 500);
        if (!m_acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: code %0d not accepted within %0d cycles", c, k);
        end
        if (k > 1) stalls++;
        det_valid = 1'b0;
        det_code  = 3'd0;
    endtask

    task automatic wait_edge(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_busy(cyc) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_done", 32'(exp_busy(cyc)), 32'd0);
        @(negedge clk);
    endtask

    logic [2:0] t3_codes [6] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};

    initial begin
        int a;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out",   32'(camera_output), 32'd0);
        chk("rst_ready", 32'(det_ready),     32'd1);
        chk("rst_busy",  32'(busy),          32'd0);
        chk("rst_drop",  32'(drop_err),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single code: one cycle of latency, H cycles of hold, then G zeros.
        send(3'd3);
        a = m_acc_edge;
        chk("t1_latency_out", 32'(camera_output), 32'd0);
        chk("t1_busy_rise",   32'(busy),          32'd1);
        chk("t1_model_first", 32'(exp_out(a + 1)), 32'd3);
        wait_edge(a + 1);
        chk("t1_first",       32'(camera_output), 32'd3);
        wait_edge(a + H);
        chk("t1_last_hold",   32'(camera_output), 32'd3);
        wait_edge(a + H + 1);
        chk("t1_after_hold",  32'(camera_output), 32'd0);
        wait_edge(a + H + G);
        chk("t1_busy_gap",    32'(busy),          32'd1);
        wait_edge(a + H + G + 1);
        chk("t1_busy_fall",   32'(busy),          32'd0);
        drain();

        // Three back-to-back codes, separated by exactly G zeros.
        send(3'd1);
        a = m_acc_edge;
        send(3'd2);
        chk("t2_no_stall_2", 32'(m_acc_edge - a), 32'd1);
        send(3'd3);
        chk("t2_no_stall_3", 32'(m_acc_edge - a), 32'd2);
        wait_edge(a + H + G);
        chk("t2_gap_end",    32'(camera_output), 32'd0);
        wait_edge(a + H + G + 1);
        chk("t2_second",     32'(camera_output), 32'd2);
        wait_edge(a + 2 * (H + G));
        chk("t2_gap2_end",   32'(camera_output), 32'd0);
        wait_edge(a + 2 * (H + G) + 1);
        chk("t2_third",      32'(camera_output), 32'd3);
        drain();

        // Burst of six codes against a depth-4 queue: back-pressure, no loss.
        seen.delete();
        stalls = 0;
        foreach (t3_codes[i]) send(t3_codes[i]);
        chk("t3_backpressure", 32'(stalls > 0), 32'd1);
        drain();
        chk("t3_count", 32'(seen.size()), 32'd6);
        foreach (t3_codes[i]) begin
            if (i < seen.size()) chk("t3_order", 32'(seen[i]), 32'(t3_codes[i]));
        end

        // Code 0 is accepted and dropped with a single pulse.
        send(3'd0);
        chk("t4_drop_pulse", 32'(drop_err),      32'd1);
        chk("t4_out",        32'(camera_output), 32'd0);
        chk("t4_busy",       32'(busy),          32'd0);
        chk("t4_ready",      32'(det_ready),     32'd1);
        @(negedge clk);
        chk("t4_drop_once",  32'(drop_err),      32'd0);

        // Asynchronous reset in the middle of DRIVE with two entries queued.
        send(3'd5);
        a = m_acc_edge;
        send(3'd1);
        send(3'd2);
        wait_edge(a + 10);
        chk("t5_driving", 32'(camera_output), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_out",   32'(camera_output), 32'd0);
        chk("t5_rst_busy",  32'(busy),          32'd0);
        chk("t5_rst_ready", 32'(det_ready),     32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("t5_idle_out",  32'(camera_output), 32'd0);
        chk("t5_idle_busy", 32'(busy),          32'd0);

        // Push on the edge that ends the last gap cycle, with the queue empty.
        send(3'd4);
        a = m_acc_edge;
        wait_edge(a + H + G);
        send(3'd6);
        chk("t6_acc_edge",  32'(m_acc_edge - a), 32'(H + G + 1));
        chk("t6_idle_slot", 32'(camera_output), 32'd0);
        chk("t6_busy",      32'(busy),          32'd1);
        wait_edge(a + H + G + 2);
        chk("t6_drive6",    32'(camera_output), 32'd6);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_camera_code_tx
`default_nettype wire
